// File: rtl/gpio_pad_ctrl_pkg.sv
// Shared types and constants for the GPIO pad sequencer.
// The debounce filter is built only when GPIO_PAD_CTRL_DEBOUNCE_EN is defined.
package gpio_pad_ctrl_pkg;

  typedef enum logic [1:0] {
    IN   = 2'd0,
    TURN = 2'd1,
    OUT  = 2'd2
  } pin_state_e;

  localparam int unsigned SYNC_DEPTH = 2;

endpackage

// File: rtl/gpio_pin_ctrl.sv
// One pad: direction sequencer with hi-Z turnaround, input synchronizer/filter, edge status.
// GPIO_PAD_CTRL_DEBOUNCE_EN adds a per-pin debounce counter in front of in_o.
module gpio_pin_ctrl
  import gpio_pad_ctrl_pkg::*;
#(
  parameter int TURN_CYC = 2,
  parameter int DB_WIDTH = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                dir_i,
  input  logic                out_i,
  input  logic                pull_en_i,
  input  logic [DB_WIDTH-1:0] db_lmt_i,
  input  logic                rise_en_i,
  input  logic                fall_en_i,
  input  logic                irq_clr_i,
  output logic                pad_out_o,
  output logic                pad_oen_o,
  output logic                pad_ren_o,
  input  logic                pad_in_i,
  output logic                in_o,
  output logic                irq_sta_o
);

  localparam int CNT_W = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TURN_CYC - 1);

  pin_state_e            state_q, state_d;
  logic                  target_out_q, target_out_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  oen_q, oen_d;
  logic                  ren_q, ren_d;
  logic                  out_q, out_d;
  logic [SYNC_DEPTH-1:0] sync_q, sync_d;
  logic                  synced;
  logic                  in_q, in_d;
  logic                  in_dly_q, in_dly_d;
  logic                  sta_q, sta_d;
  logic                  edge_set;

  always_comb begin
    state_d      = state_q;
    target_out_d = target_out_q;
    cnt_d        = cnt_q;
    case (state_q)
      IN: begin
        if (dir_i) begin
          state_d      = TURN;
          target_out_d = 1'b1;
          cnt_d        = '0;
        end
      end
      OUT: begin
        if (!dir_i) begin
          state_d      = TURN;
          target_out_d = 1'b0;
          cnt_d        = '0;
        end
      end
      TURN: begin
        // A direction reversal mid-gap restarts the full hi-Z window.
        if (dir_i != target_out_q) begin
          target_out_d = dir_i;
          cnt_d        = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = target_out_q ? OUT : IN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IN;
        cnt_d   = '0;
      end
    endcase
  end

  // Pad controls follow the next state so oen rises on the same edge OUT is left.
  always_comb begin
    oen_d = (state_d != OUT);
    ren_d = ~(pull_en_i & (state_d == IN));
    out_d = out_i;
  end

  always_comb begin
    sync_d = {sync_q[SYNC_DEPTH-2:0], pad_in_i};
  end
  assign synced = sync_q[SYNC_DEPTH-1];

`ifdef GPIO_PAD_CTRL_DEBOUNCE_EN
  logic [DB_WIDTH-1:0] db_cnt_q, db_cnt_d;

  always_comb begin
    in_d     = in_q;
    db_cnt_d = '0;
    if (synced != in_q) begin
      if (db_cnt_q >= db_lmt_i) begin
        in_d = synced;
      end else begin
        db_cnt_d = (db_cnt_q == '1) ? db_cnt_q : db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      db_cnt_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_d;
    end
  end
`else
  logic unused_db_lmt;
  assign unused_db_lmt = ^db_lmt_i;

  always_comb begin
    in_d = synced;
  end
`endif

  always_comb begin
    edge_set = (state_q == IN) &
               ((in_q & ~in_dly_q & rise_en_i) | (~in_q & in_dly_q & fall_en_i));
    in_dly_d = in_q;
    sta_d    = (sta_q & ~irq_clr_i) | edge_set;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IN;
      target_out_q <= 1'b0;
      cnt_q        <= '0;
      oen_q        <= 1'b1;
      ren_q        <= 1'b1;
      out_q        <= 1'b0;
      sync_q       <= '0;
      in_q         <= 1'b0;
      in_dly_q     <= 1'b0;
      sta_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_out_q <= target_out_d;
      cnt_q        <= cnt_d;
      oen_q        <= oen_d;
      ren_q        <= ren_d;
      out_q        <= out_d;
      sync_q       <= sync_d;
      in_q         <= in_d;
      in_dly_q     <= in_dly_d;
      sta_q        <= sta_d;
    end
  end

  assign pad_out_o = out_q;
  assign pad_oen_o = oen_q;
  assign pad_ren_o = ren_q;
  assign in_o      = in_q;
  assign irq_sta_o = sta_q;

endmodule

// File: rtl/gpio_pad_ctrl.sv
// PIN_NUM independent pad sequencers plus the combined interrupt line.
// Optional debounce is enabled with GPIO_PAD_CTRL_DEBOUNCE_EN.
module gpio_pad_ctrl
  import gpio_pad_ctrl_pkg::*;
#(
  parameter int PIN_NUM  = 8,
  parameter int TURN_CYC = 2,
  parameter int DB_WIDTH = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [PIN_NUM-1:0]  dir_i,
  input  logic [PIN_NUM-1:0]  out_i,
  input  logic [PIN_NUM-1:0]  pull_en_i,
  input  logic [DB_WIDTH-1:0] db_lmt_i,
  input  logic [PIN_NUM-1:0]  rise_en_i,
  input  logic [PIN_NUM-1:0]  fall_en_i,
  input  logic [PIN_NUM-1:0]  irq_clr_i,
  output logic [PIN_NUM-1:0]  pad_out_o,
  output logic [PIN_NUM-1:0]  pad_oen_o,
  output logic [PIN_NUM-1:0]  pad_ren_o,
  input  logic [PIN_NUM-1:0]  pad_in_i,
  output logic [PIN_NUM-1:0]  in_o,
  output logic [PIN_NUM-1:0]  irq_sta_o,
  output logic                irq_o
);

  for (genvar gi = 0; gi < PIN_NUM; gi++) begin : g_pin
    gpio_pin_ctrl #(
      .TURN_CYC (TURN_CYC),
      .DB_WIDTH (DB_WIDTH)
    ) u_pin (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .dir_i     (dir_i[gi]),
      .out_i     (out_i[gi]),
      .pull_en_i (pull_en_i[gi]),
      .db_lmt_i  (db_lmt_i),
      .rise_en_i (rise_en_i[gi]),
      .fall_en_i (fall_en_i[gi]),
      .irq_clr_i (irq_clr_i[gi]),
      .pad_out_o (pad_out_o[gi]),
      .pad_oen_o (pad_oen_o[gi]),
      .pad_ren_o (pad_ren_o[gi]),
      .pad_in_i  (pad_in_i[gi]),
      .in_o      (in_o[gi]),
      .irq_sta_o (irq_sta_o[gi])
    );
  end

  assign irq_o = |irq_sta_o;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Self-checking bench for gpio_pad_ctrl: directed scenarios plus random traffic against a cycle model.
module tb_gpio_pad_ctrl;
  localparam int PIN_NUM  = 8;
  localparam int TURN_CYC = 2;
  localparam int DB_WIDTH = 8;
  localparam int VW = 5 * PIN_NUM + 1;
  localparam int M_IN = 0, M_TURN = 1, M_OUT = 2;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [PIN_NUM-1:0]  dir_i = '0, out_i = '0, pull_en_i = '0;
  logic [PIN_NUM-1:0]  rise_en_i = '0, fall_en_i = '0, irq_clr_i = '0, pad_in_i = '0;
  logic [DB_WIDTH-1:0] db_lmt_i = '0;
  logic [PIN_NUM-1:0]  pad_out_o, pad_oen_o, pad_ren_o, in_o, irq_sta_o;
  logic                irq_o;

  int total = 0;
  int bad   = 0;

  gpio_pad_ctrl #(.PIN_NUM(PIN_NUM), .TURN_CYC(TURN_CYC), .DB_WIDTH(DB_WIDTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .dir_i(dir_i), .out_i(out_i), .pull_en_i(pull_en_i),
    .db_lmt_i(db_lmt_i), .rise_en_i(rise_en_i), .fall_en_i(fall_en_i), .irq_clr_i(irq_clr_i),
    .pad_out_o(pad_out_o), .pad_oen_o(pad_oen_o), .pad_ren_o(pad_ren_o), .pad_in_i(pad_in_i),
    .in_o(in_o), .irq_sta_o(irq_sta_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: mode per pin, countdown of remaining hi-Z cycles, pad sample history.
  int                 m_mode[PIN_NUM];
  int                 m_left[PIN_NUM];
  logic               m_goal_out[PIN_NUM];
  int                 m_run[PIN_NUM];
  logic [PIN_NUM-1:0] m_out, m_oen, m_ren, m_in, m_in_prev, m_sta;
  logic [PIN_NUM-1:0] hist[$];

  function automatic logic [VW-1:0] exp_vec();
    return {m_out, m_oen, m_ren, m_in, m_sta, |m_sta};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {pad_out_o, pad_oen_o, pad_ren_o, in_o, irq_sta_o, irq_o};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < PIN_NUM; k++) begin
      m_mode[k] = M_IN; m_left[k] = 0; m_goal_out[k] = 1'b0; m_run[k] = 0;
    end
    m_out = '0; m_oen = '1; m_ren = '1; m_in = '0; m_in_prev = '0; m_sta = '0;
    hist.delete();
  endtask

  task automatic model_edge();
    logic [PIN_NUM-1:0] synced;
    logic [PIN_NUM-1:0] set;
    int lmt;
`ifdef GPIO_PAD_CTRL_DEBOUNCE_EN
    lmt = int'(db_lmt_i);
`else
    lmt = 0;
`endif
    // The filter sees the pad value from two edges back.
    synced = (hist.size() >= 2) ? hist[1] : '0;
    hist.push_front(pad_in_i);
    if (hist.size() > 4) hist.pop_back();
    for (int k = 0; k < PIN_NUM; k++) begin
      set[k] = (m_mode[k] == M_IN) &&
               ((m_in[k] && !m_in_prev[k] && rise_en_i[k]) ||
                (!m_in[k] && m_in_prev[k] && fall_en_i[k]));
    end
    m_sta = (m_sta & ~irq_clr_i) | set;
    m_in_prev = m_in;
    for (int k = 0; k < PIN_NUM; k++) begin
      if (synced[k] != m_in[k]) begin
        m_run[k]++;
        if (m_run[k] > lmt) begin
          m_in[k] = synced[k];
          m_run[k] = 0;
        end
      end else begin
        m_run[k] = 0;
      end
      case (m_mode[k])
        M_IN: if (dir_i[k]) begin m_mode[k] = M_TURN; m_goal_out[k] = 1'b1; m_left[k] = TURN_CYC; end
        M_OUT: if (!dir_i[k]) begin m_mode[k] = M_TURN; m_goal_out[k] = 1'b0; m_left[k] = TURN_CYC; end
        default: begin
          if (dir_i[k] != m_goal_out[k]) begin
            m_goal_out[k] = dir_i[k];
            m_left[k] = TURN_CYC;
          end else begin
            m_left[k]--;
            if (m_left[k] == 0) m_mode[k] = m_goal_out[k] ? M_OUT : M_IN;
          end
        end
      endcase
      m_oen[k] = (m_mode[k] != M_OUT);
      m_ren[k] = !(pull_en_i[k] && m_mode[k] == M_IN);
    end
    m_out = out_i;
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    if (pad_oen_o !== '1) begin bad++; $display("FAIL reset_oen got %b want %b", pad_oen_o, {PIN_NUM{1'b1}}); end
    if (pad_out_o !== '0) begin bad++; $display("FAIL reset_out got %b want 0", pad_out_o); end
    if (pad_ren_o !== '1) begin bad++; $display("FAIL reset_ren got %b want all 1", pad_ren_o); end
    if (in_o !== '0) begin bad++; $display("FAIL reset_in got %b want 0", in_o); end
    if (irq_sta_o !== '0) begin bad++; $display("FAIL reset_sta got %b want 0", irq_sta_o); end
    if (irq_o !== 1'b0) begin bad++; $display("FAIL reset_irq got %b want 0", irq_o); end
    total += 6;
    $display("reset: checked reset values");
    rst_i = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) tick();
  endtask

  task automatic test_dir_seq();
    pull_en_i[0] = 1'b1; out_i[0] = 1'b1; dir_i[0] = 1'b1;
    for (int k = 1; k <= TURN_CYC + 2; k++) begin
      tick();
      if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL in_to_out step %0d got %h want %h", k, dut_vec(), exp_vec()); end
      if (pad_oen_o[0] !== 1'(k <= TURN_CYC)) begin bad++; $display("FAIL oen_fall step %0d got %b want %b", k, pad_oen_o[0], k <= TURN_CYC); end
      if (pad_ren_o[0] !== 1'b1) begin bad++; $display("FAIL ren_release step %0d got %b want 1", k, pad_ren_o[0]); end
      if (pad_out_o[0] !== 1'b1) begin bad++; $display("FAIL pad_out step %0d got %b want 1", k, pad_out_o[0]); end
      total += 4;
    end
    $display("dir_seq: IN->OUT sequence done");
    dir_i[0] = 1'b0;
    for (int k = 1; k <= TURN_CYC + 2; k++) begin
      tick();
      if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL out_to_in step %0d got %h want %h", k, dut_vec(), exp_vec()); end
      if (pad_oen_o[0] !== 1'b1) begin bad++; $display("FAIL oen_rise step %0d got %b want 1", k, pad_oen_o[0]); end
      if (pad_ren_o[0] !== 1'(k <= TURN_CYC)) begin bad++; $display("FAIL ren_on_in step %0d got %b want %b", k, pad_ren_o[0], k <= TURN_CYC); end
      total += 3;
    end
    $display("dir_seq: OUT->IN sequence done");
    dir_i[0] = 1'b1;
    for (int k = 0; k < TURN_CYC + 2; k++) tick();
    dir_i[0] = 1'b0;
    for (int k = 1; k <= TURN_CYC + 2; k++) begin
      if (k == 2) dir_i[0] = 1'b1;
      tick();
      if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL turn_flip step %0d got %h want %h", k, dut_vec(), exp_vec()); end
      if (pad_oen_o[0] !== 1'(k <= TURN_CYC + 1)) begin bad++; $display("FAIL flip_oen step %0d got %b want %b", k, pad_oen_o[0], k <= TURN_CYC + 1); end
      total += 2;
    end
    $display("dir_seq: TURN reversal done");
  endtask

  task automatic test_irq();
    db_lmt_i = '0; rise_en_i[1] = 1'b1; fall_en_i[1] = 1'b1; pad_in_i[1] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL irq_rise step %0d got %h want %h", k, dut_vec(), exp_vec()); end
      if (in_o[1] !== 1'(k >= 3)) begin bad++; $display("FAIL in_latency step %0d got %b want %b", k, in_o[1], k >= 3); end
      if (irq_sta_o[1] !== 1'(k >= 4)) begin bad++; $display("FAIL sta_set step %0d got %b want %b", k, irq_sta_o[1], k >= 4); end
      if (irq_o !== 1'(k >= 4)) begin bad++; $display("FAIL irq_or step %0d got %b want %b", k, irq_o, k >= 4); end
      total += 4;
    end
    irq_clr_i[1] = 1'b1;
    tick();
    irq_clr_i[1] = 1'b0;
    if (irq_sta_o[1] !== 1'b0) begin bad++; $display("FAIL sta_clear got %b want 0", irq_sta_o[1]); end
    if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL clear_all got %h want %h", dut_vec(), exp_vec()); end
    total += 2;
    pad_in_i[1] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) irq_clr_i[1] = 1'b1;
      tick();
      if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL clr_vs_set step %0d got %h want %h", k, dut_vec(), exp_vec()); end
      total++;
    end
    irq_clr_i[1] = 1'b0;
    if (irq_sta_o[1] !== 1'b1) begin bad++; $display("FAIL set_wins got %b want 1", irq_sta_o[1]); end
    total++;
    $display("irq: rise, clear, clear-vs-set done");
  endtask

  task automatic test_debounce();
`ifdef GPIO_PAD_CTRL_DEBOUNCE_EN
    db_lmt_i = 8'd4;
    for (int k = 1; k <= 12; k++) begin
      pad_in_i[2] = (k <= 3);
      tick();
      if (in_o[2] !== 1'b0) begin bad++; $display("FAIL glitch_block step %0d got %b want 0", k, in_o[2]); end
      if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL glitch_all step %0d got %h want %h", k, dut_vec(), exp_vec()); end
      total += 2;
    end
    pad_in_i[2] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (in_o[2] !== 1'(k >= 7)) begin bad++; $display("FAIL db_latency step %0d got %b want %b", k, in_o[2], k >= 7); end
      if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL db_all step %0d got %h want %h", k, dut_vec(), exp_vec()); end
      total += 2;
    end
    $display("debounce: glitch filtered, stable change passed");
`else
    db_lmt_i = 8'd4;
    for (int k = 1; k <= 6; k++) begin
      pad_in_i[2] = (k == 1);
      tick();
      if (in_o[2] !== 1'(k == 3)) begin bad++; $display("FAIL pass_thru step %0d got %b want %b", k, in_o[2], k == 3); end
      if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL pass_all step %0d got %h want %h", k, dut_vec(), exp_vec()); end
      total += 2;
    end
    $display("debounce: disabled build, single-cycle pulse passes");
`endif
  endtask

  task automatic test_random();
    int errs;
    errs = bad;
    for (int c = 0; c < 1500; c++) begin
      dir_i     ^= PIN_NUM'($urandom & $urandom & $urandom);
      pad_in_i  ^= PIN_NUM'($urandom & $urandom);
      out_i      = PIN_NUM'($urandom);
      pull_en_i  = PIN_NUM'($urandom);
      irq_clr_i  = PIN_NUM'($urandom & $urandom & $urandom & $urandom);
      if (c % 64 == 0) begin
        rise_en_i = PIN_NUM'($urandom);
        fall_en_i = PIN_NUM'($urandom);
      end
      if (c % 100 == 0) db_lmt_i = DB_WIDTH'($urandom_range(0, 3));
      tick();
      if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL random cycle %0d got %h want %h", c, dut_vec(), exp_vec()); end
      total++;
    end
    irq_clr_i = '0;
    $display("random: 1500 cycles, new errors %0d", bad - errs);
  endtask

  task automatic test_async_reset();
    dir_i = '0; db_lmt_i = '0;
    for (int k = 0; k < TURN_CYC + 3; k++) tick();
    rise_en_i = '1; fall_en_i = '1; pad_in_i = ~m_in;
    for (int k = 0; k < 5; k++) tick();
    if (irq_sta_o !== '1) begin bad++; $display("FAIL pre_rst_sta got %b want all 1", irq_sta_o); end
    total++;
    dir_i = '1;
    for (int k = 0; k < TURN_CYC + 3; k++) tick();
    dir_i[3:0] = '0;
    tick();
    if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL pre_rst_all got %h want %h", dut_vec(), exp_vec()); end
    total++;
    #2 rst_i = 1'b1;
    #1;
    if (pad_oen_o !== '1) begin bad++; $display("FAIL async_oen got %b want all 1", pad_oen_o); end
    if (irq_sta_o !== '0) begin bad++; $display("FAIL async_sta got %b want 0", irq_sta_o); end
    if (irq_o !== 1'b0) begin bad++; $display("FAIL async_irq got %b want 0", irq_o); end
    if (pad_ren_o !== '1) begin bad++; $display("FAIL async_ren got %b want all 1", pad_ren_o); end
    if (in_o !== '0) begin bad++; $display("FAIL async_in got %b want 0", in_o); end
    total += 5;
    $display("async_reset: outputs checked before next clock edge");
    @(negedge clk_i);
    dir_i = '0; pad_in_i = '0; rise_en_i = '0; fall_en_i = '0;
    rst_i = 1'b0;
    model_reset();
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL post_rst step %0d got %h want %h", k, dut_vec(), exp_vec()); end
      total++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_dir_seq();
    test_irq();
    test_debounce();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
